// File: rtl/scaler_v_sched.sv
// scaler_v_sched -- row scheduler for the vertical scaling DSP stage.
//
// For every output row it derives the source row (iy) and the filter phase
// from a fixed-point position accumulator. It waits until the line buffer
// holds the bottom row of the kernel window, then streams one column per
// ready cycle of line-buffer reads. Once the last column has passed the
// read and DSP latency it reports the row as done, and after the last row
// it reports the frame as done.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_start         one-cycle start pulse, latches cfg_* (dropped when busy)
//   cfg_dst_width     output columns per row (>=1)
//   cfg_dst_height    output rows (>=1)
//   cfg_src_height    source rows (>=1)
//   cfg_v_step        src/dst ratio, STEP_FRAC fractional bits
//   lb_line_cnt       source rows already written to the line buffer
//   out_ready         downstream accepts new columns
//   busy              frame in progress
//   rd_en/rd_row/rd_col  line-buffer read strobe, top window row, column
//   coef_phase        coefficient phase, constant for the whole row
//   dsp_din_en        rd_en delayed by RD_LATENCY (aligned to read data)
//   row_done          pulse when the row's last result leaves the DSP
//   frame_done        pulse together with the last row_done
//   lb_release_row    lowest source row still needed
//
// Optional build macro SCALER_V_SCHED_STAT_EN adds stat_stall_cnt: the
// number of WAIT cycles plus RUN cycles with out_ready low. It clears on
// an accepted cfg_start and saturates at all-ones.
module scaler_v_sched #(
  parameter int KERNEL_MAX      = 4,
  parameter int PHASE_BITWIDTH  = 5,
  parameter int STEP_FRAC       = 16,
  parameter int WIDTH_BITWIDTH  = 12,
  parameter int HEIGHT_BITWIDTH = 12,
  parameter int RD_LATENCY      = 1,
  parameter int DSP_LATENCY     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_start,
  input  logic [WIDTH_BITWIDTH-1:0]           cfg_dst_width,
  input  logic [HEIGHT_BITWIDTH-1:0]          cfg_dst_height,
  input  logic [HEIGHT_BITWIDTH-1:0]          cfg_src_height,
  input  logic [HEIGHT_BITWIDTH+STEP_FRAC-1:0] cfg_v_step,
  input  logic [HEIGHT_BITWIDTH:0]            lb_line_cnt,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                rd_en,
  output logic [HEIGHT_BITWIDTH-1:0]          rd_row,
  output logic [WIDTH_BITWIDTH-1:0]           rd_col,
  output logic [PHASE_BITWIDTH-1:0]           coef_phase,
  output logic                                dsp_din_en,
  output logic                                row_done,
  output logic                                frame_done,
  output logic [HEIGHT_BITWIDTH-1:0]          lb_release_row
`ifdef SCALER_V_SCHED_STAT_EN
  ,output logic [31:0]                        stat_stall_cnt
`endif
);
  localparam int ACC_W     = HEIGHT_BITWIDTH + STEP_FRAC;
  localparam int HALF      = KERNEL_MAX / 2;
  localparam int DRAIN_LAT = RD_LATENCY + DSP_LATENCY;
  localparam int CNT_W     = $clog2(DRAIN_LAT + 1);
  localparam logic [HEIGHT_BITWIDTH-1:0] TOP_OFS = HEIGHT_BITWIDTH'(HALF - 1);
  localparam logic [HEIGHT_BITWIDTH:0]   BOT_OFS = (HEIGHT_BITWIDTH+1)'(HALF);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [WIDTH_BITWIDTH-1:0]  dst_width;
  logic [HEIGHT_BITWIDTH-1:0] dst_height, src_height, dst_row;
  logic [ACC_W-1:0]           v_step, acc, acc_adv;
  logic [ACC_W:0]             acc_sum;
  logic [CNT_W-1:0]           drain_cnt;
  logic [RD_LATENCY:1]        vld_pipe;

  logic [HEIGHT_BITWIDTH-1:0] iy, top;
  logic [HEIGHT_BITWIDTH:0]   bot_raw, src_max, bot;
  logic                       lines_ok, col_last, row_last, drain_done;

  // Kernel window, clamped to the source frame.
  assign iy      = acc[ACC_W-1:STEP_FRAC];
  assign top     = (iy >= TOP_OFS) ? (iy - TOP_OFS) : '0;
  assign bot_raw = {1'b0, iy} + BOT_OFS;
  assign src_max = {1'b0, src_height} - (HEIGHT_BITWIDTH+1)'(1);
  assign bot     = (bot_raw > src_max) ? src_max : bot_raw;

  // Whole source frame already buffered also releases the wait.
  assign lines_ok   = (lb_line_cnt > bot) || (lb_line_cnt >= {1'b0, src_height});
  assign col_last   = (rd_col == dst_width - WIDTH_BITWIDTH'(1));
  assign row_last   = (dst_row == dst_height - HEIGHT_BITWIDTH'(1));
  assign drain_done = (drain_cnt == CNT_W'(DRAIN_LAT));

  // Accumulator advance saturates instead of wrapping.
  assign acc_sum = {1'b0, acc} + {1'b0, v_step};
  assign acc_adv = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  assign busy           = (state != S_IDLE);
  assign rd_row         = top;
  assign lb_release_row = top;
  assign coef_phase     = acc[STEP_FRAC-1 -: PHASE_BITWIDTH];
  assign dsp_din_en     = vld_pipe[RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    row_done   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (cfg_start) state_nxt = S_WAIT;
      S_WAIT:  if (lines_ok)  state_nxt = S_RUN;
      S_RUN: begin
        if (out_ready) begin
          rd_en = 1'b1;
          if (col_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          row_done = 1'b1;
          if (row_last) begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            state_nxt  = S_WAIT;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_width  <= '0;
      dst_height <= '0;
      src_height <= '0;
      v_step     <= '0;
      acc        <= '0;
      dst_row    <= '0;
      rd_col     <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            dst_width  <= cfg_dst_width;
            dst_height <= cfg_dst_height;
            src_height <= cfg_src_height;
            v_step     <= cfg_v_step;
            acc        <= '0;
            dst_row    <= '0;
            rd_col     <= '0;
          end
        end
        S_WAIT: rd_col <= '0;
        S_RUN: begin
          drain_cnt <= '0;
          if (out_ready && !col_last) rd_col <= rd_col + WIDTH_BITWIDTH'(1);
        end
        S_DRAIN: begin
          if (drain_done) begin
            drain_cnt <= '0;
            // Park the accumulator at 0 after the frame so idle outputs are clean.
            if (row_last) acc <= '0;
            else begin
              acc     <= acc_adv;
              dst_row <= dst_row + HEIGHT_BITWIDTH'(1);
            end
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read-latency alignment of the DSP enable; reset discards in-flight bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_en;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

`ifdef SCALER_V_SCHED_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_stall_cnt <= '0;
    else if (state == S_IDLE && cfg_start) stat_stall_cnt <= '0;
    else if (((state == S_WAIT) || (state == S_RUN && !out_ready)) &&
             (stat_stall_cnt != 32'hFFFF_FFFF))
      stat_stall_cnt <= stat_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/scaler_v_sched.md
Name: scaler_v_sched

Overview:
Row scheduler for the vertical scaling DSP stage. For each output row it computes the source row position and filter phase. It waits until the line buffer holds every source row the kernel needs, then issues one column per cycle of line-buffer reads and matching DSP enables. It tracks the in-flight pipeline and reports row and frame completion. It sits between the line buffer writer, the line buffer read port, the coefficient table and the vertical DSP array.

Parameters:
KERNEL_MAX, 4, vertical taps; must be even and at least 2
PHASE_BITWIDTH, 5, coefficient phase index width (2^5 = 32 phases)
STEP_FRAC, 16, fractional bits of the vertical step and of the position accumulator
WIDTH_BITWIDTH, 12, column count width
HEIGHT_BITWIDTH, 12, row count width
RD_LATENCY, 1, line-buffer read latency in cycles (rd_en to data valid)
DSP_LATENCY, 4, DSP latency in cycles (din_en to dout_en)

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and starts a frame; ignored while busy
cfg_dst_width  in  WIDTH_BITWIDTH  output columns per row, >=1
cfg_dst_height  in  HEIGHT_BITWIDTH  output rows, >=1
cfg_src_height  in  HEIGHT_BITWIDTH  source rows, >=1
cfg_v_step  in  HEIGHT_BITWIDTH+STEP_FRAC  src/dst ratio, unsigned, STEP_FRAC fractional bits
lb_line_cnt  in  HEIGHT_BITWIDTH+1  source rows fully written to the line buffer this frame
out_ready  in  1  downstream can accept new columns
busy  out  1  frame in progress
rd_en  out  1  line-buffer read strobe
rd_row  out  HEIGHT_BITWIDTH  top source row of the kernel window (clamped)
rd_col  out  WIDTH_BITWIDTH  column being read
coef_phase  out  PHASE_BITWIDTH  coefficient phase index for the current row
dsp_din_en  out  1  DSP enable, aligned to line-buffer data
row_done  out  1  one-cycle pulse when the current row's last result leaves the DSP
frame_done  out  1  one-cycle pulse when the last row is done
lb_release_row  out  HEIGHT_BITWIDTH  lowest source row still needed; rows below it may be overwritten

Behaviour:
- Reset: clock clk; reset rst_n is asynchronous and active-low. While reset is asserted, all outputs are 0, the FSM is IDLE and the accumulator is 0.
- Position accumulator acc: 0 at frame start; after each row_done, acc += cfg_v_step.
- iy = acc >> STEP_FRAC.
- coef_phase = acc[STEP_FRAC-1 -: PHASE_BITWIDTH], held constant for the whole row.
- Kernel window:
  - top = iy - (KERNEL_MAX/2 - 1), clamped to a minimum of 0
  - bot = iy + KERNEL_MAX/2, clamped to a maximum of cfg_src_height - 1
  - rd_row = top; lb_release_row = top
- FSM states:
  - IDLE: cfg_start -> WAIT; busy = 1 from the next cycle.
  - WAIT: when lb_line_cnt > bot, or lb_line_cnt >= cfg_src_height, go to RUN with rd_col = 0.
  - RUN:
    - Each cycle with out_ready = 1: rd_en = 1 and rd_col increments.
    - out_ready = 0: rd_en = 0 and rd_col holds.
    - After the column cfg_dst_width - 1 is issued, go to DRAIN.
  - DRAIN: a counter runs RD_LATENCY + DSP_LATENCY cycles after the last rd_en, then row_done pulses.
    - If dst_row == cfg_dst_height - 1: frame_done pulses in the same cycle as row_done, and the FSM goes to IDLE with busy = 0 the next cycle.
    - Otherwise dst_row increments, acc advances, and the FSM goes to WAIT.
- Output timing:
  - dsp_din_en is rd_en delayed by exactly RD_LATENCY cycles, through a shift register.
  - Back-pressure affects only new issues. Downstream must absorb up to RD_LATENCY + DSP_LATENCY in-flight columns.
- Boundaries:
  - cfg_dst_width = 1: RUN lasts 1 issue cycle.
  - Rows near the top and bottom are clamped, never negative or past cfg_src_height - 1.
  - acc saturates at its maximum and never wraps.
  - cfg_start while busy is dropped.
  - lb_line_cnt decreasing mid-frame is not supported.
  - Asserting rst_n mid-row aborts immediately: all outputs clear, in-flight enables are discarded.

Optional Feature:
SCALER_V_SCHED_STAT_EN.
- Defined: adds output stat_stall_cnt [31:0], the number of cycles spent in WAIT plus RUN cycles with out_ready = 0. It clears on cfg_start and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Unity scale: src 8x8, dst_width 8, dst_height 8, v_step 0x10000, lb_line_cnt = 8 held -> 8 row_done pulses; rd_row sequence 0,0,1,2,3,4,5,6; coef_phase always 0; frame_done with the 8th row_done.
- 2x upscale: src 4 rows, dst 8 rows, v_step 0x8000 -> coef_phase alternates 0,16; iy sequence 0,0,1,1,2,2,3,3; 8 dst_width issues per row.
- Line gating: lb_line_cnt held at 2 with v_step 0x10000 -> FSM stays in WAIT (bot = 2); raising lb_line_cnt to 3 -> rd_en asserts within 2 cycles.
- Back-pressure: dst_width 16, out_ready low for cycles 5-9 of RUN -> exactly 16 rd_en pulses; rd_col continuous 0..15; dsp_din_en equals rd_en delayed by RD_LATENCY.
- Drain timing: row_done occurs exactly RD_LATENCY + DSP_LATENCY + 1 cycles after the last rd_en; a cfg_start issued while busy is ignored.
- Reset mid-RUN: drop rst_n at rd_col = 5 -> all outputs 0 asynchronously; after release the FSM is IDLE and a new cfg_start runs a clean frame.
